// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;

    // Counter reload value: the sample is taken once the counter has run down to zero.
    function automatic logic [CNT_W-1:0] dwell_reload(input int dwell);
        return CNT_W'(dwell - 1);
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Handshake/bus bundle between the scan controller and its mux and frame consumer.
// frame_parity exists only when MUX_SCAN_PARITY_EN is defined.
interface mux_scan_ctrl_if
    import mux_scan_pkg::*;
();
    logic              start;
    logic [SEL_W-1:0]  sel;
    logic              y_in;
    logic [NUM_CH-1:0] frame;
    logic              frame_valid;
    logic              frame_ready;
    logic              busy;
`ifdef MUX_SCAN_PARITY_EN
    logic              frame_parity;

    modport master (
        input  start, y_in, frame_ready,
        output sel, frame, frame_valid, busy, frame_parity
    );

    modport slave (
        output start, y_in, frame_ready,
        input  sel, frame, frame_valid, busy, frame_parity
    );
`else
    modport master (
        input  start, y_in, frame_ready,
        output sel, frame, frame_valid, busy
    );

    modport slave (
        output start, y_in, frame_ready,
        input  sel, frame, frame_valid, busy
    );
`endif

endinterface

// File: rtl/mux_scan_dwell.sv
// Dwell down-counter: load, decrement-to-zero, zero flag.
module mux_scan_dwell
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans four mux channels with a per-channel dwell, assembles a frame and hands it off
// over a valid/ready handshake. Optional frame_parity output under MUX_SCAN_PARITY_EN.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL      = 2,
    parameter int CONTINUOUS = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_scan_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] RELOAD = dwell_reload(DWELL);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] cap_q, cap_d;
    logic [NUM_CH-1:0] frame_q, frame_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              cnt_load, cnt_dec, cnt_zero;
`ifdef MUX_SCAN_PARITY_EN
    logic              parity_q, parity_d;
`endif

    mux_scan_dwell u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (RELOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cap_d    = cap_q;
        frame_d  = frame_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        case (state_q)
            IDLE: begin
                sel_d = '0;
                if (bus.start) begin
                    cnt_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    cap_d[sel_q] = bus.y_in;
                    if (sel_q != LAST_CH) begin
                        sel_d    = sel_q + 1'b1;
                        cnt_load = 1'b1;
                    end else begin
                        // The freshly sampled last channel must be part of the frame.
                        frame_d = cap_d;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (valid_q && bus.frame_ready) begin
                    sel_d = '0;
                    if ((CONTINUOUS != 0) || bus.start) begin
                        cnt_load = 1'b1;
                        state_d  = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                sel_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Status flags are registered copies of the next state.
        valid_d = (state_d == HOLD);
        busy_d  = (state_d != IDLE);
    end

`ifdef MUX_SCAN_PARITY_EN
    assign parity_d = ^frame_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cap_q    <= '0;
            frame_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cap_q    <= cap_d;
            frame_q  <= frame_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.sel         = sel_q;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = valid_q;
    assign bus.busy        = busy_q;
`ifdef MUX_SCAN_PARITY_EN
    assign bus.frame_parity = parity_q;
`endif

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 2, clock cycles each channel select is held before its sample is taken (legal range 1..255).
REQ-002 Parameter CONTINUOUS, default 0; when 1, a new scan starts automatically after each frame is accepted.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 start  input  1  request one scan; sampled only in IDLE.
REQ-006 sel  output  2  channel select driven to the downstream 4:1 mux select input.
REQ-007 y_in  input  1  mux output for the currently selected channel.
REQ-008 frame  output  4  captured frame; bit i holds the sample taken with sel==i.
REQ-009 frame_valid  output  1  frame available.
REQ-010 frame_ready  input  1  consumer accepts frame.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states:
- IDLE
- SETTLE: select held, dwell counter running
- HOLD: frame_valid high, waiting for frame_ready
REQ-013 In IDLE, start high at a rising edge SHALL set sel=0, load the dwell counter with DWELL-1, and enter SETTLE.
REQ-014 In SETTLE with counter non-zero, the counter SHALL decrement by one per cycle, with sel unchanged.
REQ-015 In SETTLE with counter zero, the block SHALL capture y_in into capture bit [sel] at that edge.
- sel<3: increment sel and reload the counter with DWELL-1.
- sel==3: copy the full capture register to frame and enter HOLD.
REQ-016 Latency: with start accepted at edge 0, channel i SHALL be sampled at edge (i+1)*DWELL, and frame_valid SHALL be high from edge 4*DWELL onward.
REQ-017 The frame output SHALL change only on entry to HOLD, and SHALL remain stable while frame_valid is high and frame_ready is low.
REQ-018 In HOLD, frame_valid and frame_ready both high at an edge SHALL transfer the frame.
- Next state SETTLE (sel=0, counter reloaded) if CONTINUOUS==1 or start is high at that edge.
- Otherwise next state IDLE.
REQ-019 start SHALL be ignored in SETTLE and ensures no restart mid-scan; in HOLD it matters only at the transfer edge.
REQ-020 sel SHALL hold its last value in HOLD, and SHALL be 0 in IDLE.
REQ-021 frame_ready while frame_valid is low SHALL have no effect.

Reset
REQ-022 rst_n low SHALL force, asynchronously and regardless of the current state (including mid-scan):
- state=IDLE, sel=0, counter=0
- capture register=0, frame=0
- frame_valid=0, busy=0
REQ-023 After reset, the first scan SHALL require start (or CONTINUOUS==1 plus an initial start).

Configuration
REQ-024 Macro MUX_SCAN_PARITY_EN, when defined, SHALL add output port frame_parity (1 bit).
- frame_parity equals XOR of the four frame bits.
- It is updated together with frame, and reset to 0.
REQ-025 When MUX_SCAN_PARITY_EN is undefined, frame_parity and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Shared package mux_scan_pkg SHALL hold:
- state enum (IDLE, SETTLE, HOLD)
- constant NUM_CH=4
- constant SEL_W=2
REQ-027 The dwell counter SHALL be a sub-module mux_scan_dwell (load, decrement, zero flag, width 8); all other logic is in mux_scan_ctrl.

Verification
REQ-028 DWELL=2, mux model with t=4'b1010, start pulsed one cycle -> sel sequence 0,0,1,1,2,2,3,3; frame=4'b1010 with frame_valid high at edge 8.
REQ-029 DWELL=1, t=4'b0110, frame_ready held low for 5 cycles after valid -> frame stays 4'b0110 and valid stays high; single transfer on ready; returns to IDLE, busy=0.
REQ-030 CONTINUOUS=1, t changed from 4'b0001 to 4'b1000 between scans -> back-to-back frames 4'b0001 then 4'b1000; no IDLE between them.
REQ-031 rst_n asserted low mid-SETTLE at sel=2 -> all outputs 0 immediately without a clock edge; start after release yields a full 4-channel scan from sel=0.
REQ-032 start pulses during SETTLE -> ignored; exactly one frame produced.
REQ-033 MUX_SCAN_PARITY_EN defined, t=4'b0111 -> frame_parity=1; t=4'b0101 -> frame_parity=0.
